ibex_mem_xbar_ctrl: RTL and testbench

Parametrised shared-memory controller replacing the tied-off instruction ROM / data SRAM pair with grant-always-high. Arbitrates NumPorts Ibex-style request channels (e.g. port 0 = instr, port 1 = data, extra ports for DMA/taint probes) onto one single-ported word array. Provides real gnt back-pressure, a configurable read latency, rvalid/err responses and bitwise write masks. Sits between the Ibex memory interfaces and the backing storage in the tiny SoC.

---
 rtl/ibex_mem_xbar_pkg.sv | 20 ++
 rtl/ibex_mem_rr_arb.sv | 48 ++++
 rtl/ibex_mem_xbar_ctrl.sv | 131 +++++++++++++
 tb/tb_ibex_mem_xbar_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_mem_xbar_pkg.sv
// Shared types and parameter legality helpers for the Ibex shared-memory crossbar controller.
package ibex_mem_xbar_pkg;

  localparam int unsigned MaxPorts = 8;

  typedef logic [$clog2(MaxPorts)-1:0] port_idx_t;

  function automatic bit ports_ok(int unsigned n);
    return (n >= 1) && (n <= MaxPorts);
  endfunction

  function automatic bit latency_ok(int unsigned l);
    return (l >= 1) && (l <= 4);
  endfunction

  function automatic bit addr_width_ok(int unsigned aw, int unsigned depth);
    return aw >= ($clog2(depth) + 1);
  endfunction

endpackage

// File: rtl/ibex_mem_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting at ptr_q, pointer advances past the winner.
module ibex_mem_rr_arb
  import ibex_mem_xbar_pkg::*;
#(
  parameter int unsigned NumPorts = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic [NumPorts-1:0] req_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic                gnt_valid_o,
  output port_idx_t           gnt_idx_o
);

  localparam int unsigned IW = $bits(port_idx_t);

  port_idx_t ptr_q, ptr_d;
  logic [NumPorts-1:0] upper_mask, masked_req, pick_src, pick;
  logic [NumPorts:0][IW-1:0] idx_or;

  assign idx_or[0] = '0;
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign upper_mask[p] = (port_idx_t'(p) >= ptr_q);
    assign idx_or[p+1]   = idx_or[p] | (gnt_o[p] ? port_idx_t'(p) : '0);
  end

  // Ports at or above the pointer win first; otherwise wrap to the lowest requester.
  assign masked_req  = req_i & upper_mask;
  assign pick_src    = (|masked_req) ? masked_req : req_i;
  assign pick        = pick_src & (~pick_src + NumPorts'(1));
  assign gnt_o       = (stall_i || rst_i) ? '0 : pick;
  assign gnt_valid_o = |gnt_o;
  assign gnt_idx_o   = idx_or[NumPorts];

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (gnt_idx_o == port_idx_t'(NumPorts - 1)) ? '0 : gnt_idx_o + port_idx_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ibex_mem_xbar_ctrl.sv
// Shared single-ported word memory arbitrated between NumPorts Ibex-style channels.
// Responses (rvalid/rdata/err) emerge ReadLatency cycles after grant, in grant order.
module ibex_mem_xbar_ctrl
  import ibex_mem_xbar_pkg::*;
#(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 1 << 15,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned AddrWidth   = $clog2(Depth) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  input  logic [NumPorts-1:0]           req_i,
  output logic [NumPorts-1:0]           gnt_o,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts-1:0]           we_i,
  input  logic [NumPorts*Width-1:0]     wmask_i,
  input  logic [NumPorts*Width-1:0]     wdata_i,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [Width-1:0]              rdata_o,
  output logic                          err_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PW   = AddrWidth + 1 + 2 * Width;

  typedef struct packed {
    logic             valid;
    port_idx_t        port;
    logic             err;
    logic [Width-1:0] data;
  } resp_entry_t;

  logic        gnt_valid;
  port_idx_t   gnt_idx;

  ibex_mem_rr_arb #(.NumPorts(NumPorts)) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .stall_i    (stall_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  // One-hot AND-OR select of the granted port's request fields.
  logic [NumPorts:0][PW-1:0] sel_or;
  logic [AddrWidth-1:0]      sel_addr;
  logic                      sel_we;
  logic [Width-1:0]          sel_mask, sel_wdata;

  assign sel_or[0] = '0;
  for (genvar p = 0; p < NumPorts; p++) begin : g_sel
    assign sel_or[p+1] = sel_or[p] | ({PW{gnt_o[p]}} &
                         {addr_i[p*AddrWidth +: AddrWidth], we_i[p],
                          wmask_i[p*Width +: Width], wdata_i[p*Width +: Width]});
  end
  assign {sel_addr, sel_we, sel_mask, sel_wdata} = sel_or[NumPorts];

  logic            sel_oor;
  logic [IdxW-1:0] sel_idx;
  assign sel_oor = (sel_addr >= AddrWidth'(Depth));
  assign sel_idx = sel_addr[IdxW-1:0];

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (gnt_valid && sel_we && !sel_oor) begin
      mem_q[sel_idx] <= (mem_q[sel_idx] & ~sel_mask) | (sel_wdata & sel_mask);
    end
  end

  resp_entry_t entry_d;
  resp_entry_t pipe_q [ReadLatency];
  resp_entry_t resp;

  // Reads sample the pre-write word; idle slots are all-zero so outputs stay quiet.
  always_comb begin
    entry_d       = '0;
    entry_d.valid = gnt_valid;
    if (gnt_valid) begin
      entry_d.port = gnt_idx;
      entry_d.err  = sel_oor;
      entry_d.data = (!sel_we && !sel_oor) ? mem_q[sel_idx] : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= entry_d;
      for (int i = 1; i < ReadLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign resp     = pipe_q[ReadLatency-1];
  assign rvalid_o = resp.valid ? (NumPorts'(1) << resp.port) : '0;
  assign rdata_o  = resp.data;
  assign err_o    = resp.err;

`ifndef SYNTHESIS
  int unsigned gnt_cnt_q, rsp_cnt_q, inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < ReadLatency; i++) inflight = inflight + 32'(pipe_q[i].valid);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_cnt_q <= 0;
      rsp_cnt_q <= 0;
    end else begin
      gnt_cnt_q <= gnt_cnt_q + 32'(gnt_valid);
      rsp_cnt_q <= rsp_cnt_q + 32'(resp.valid);
    end
  end

  a_params_legal: assert property (@(posedge clk_i)
    ports_ok(NumPorts) && latency_ok(ReadLatency) && addr_width_ok(AddrWidth, Depth));
  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o));
  a_resp_count: assert property (@(posedge clk_i) disable iff (rst_i)
    gnt_cnt_q == rsp_cnt_q + inflight);
`endif

endmodule

// File: tb/tb_ibex_mem_xbar_ctrl.sv
// Directed bench for ibex_mem_xbar_ctrl: 3 ports, 1024 words, read latency 2.
module tb_ibex_mem_xbar_ctrl;

  localparam int NP    = 3;
  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = 11;
  localparam int EW    = NP + 1 + W;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [NP-1:0]     req, gnt, we, rvalid;
  logic [NP*AW-1:0]  addr;
  logic [NP*W-1:0]   wmask, wdata;
  logic [W-1:0]      rdata;
  logic              err;

  // clock / reset
  always #5 clk = ~clk;

  ibex_mem_xbar_ctrl #(
    .NumPorts(NP), .Width(W), .Depth(DEPTH), .ReadLatency(LAT), .AddrWidth(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .req_i(req), .gnt_o(gnt),
    .addr_i(addr), .we_i(we), .wmask_i(wmask), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    int           port;
    logic         we;
    logic [AW-1:0] addr;
    logic [W-1:0] mask;
    logic [W-1:0] data;
    logic         exp_err;
    logic [W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] exp_entry(input int p, input logic e, input logic [W-1:0] d);
    logic [NP-1:0] oh;
    oh = 1;
    oh = oh << p;
    return {oh, e, d};
  endfunction

  // scoreboard: every rvalid pops the oldest expected response
  always @(negedge clk) begin
    if (!rst && rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h err=%b, expected none", rvalid, rdata, err);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("response", 64'({rvalid, err, rdata}), 64'(e));
      end
    end
  end

  // driver tasks
  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [W-1:0] m, input logic [W-1:0] d);
    we[p]            = w;
    addr[p*AW +: AW] = a;
    wmask[p*W +: W]  = m;
    wdata[p*W +: W]  = d;
  endtask

  task automatic wait_drain(input string name);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_txn(input vec_t v);
    logic [NP-1:0] r;
    int lat;
    r = 1;
    @(negedge clk);
    set_port(v.port, v.we, v.addr, v.mask, v.data);
    req = r << v.port;
    #1;
    chk("vec_gnt", 64'(gnt), 64'(req));
    exp_q.push_back(exp_entry(v.port, v.exp_err, v.exp_rdata));
    @(posedge clk);
    #1;
    req = '0;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rvalid !== '0) begin
        lat = k;
        break;
      end
    end
    chk("vec_latency", 64'(lat), 64'(LAT));
    wait_drain("vec_drain");
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [W-1:0] cdata [3];
    vec_t v;
    rst = 1'b1; stall = 1'b0; req = '0; we = '0; addr = '0; wmask = '0; wdata = '0;

    //         port we    addr        mask          data          err   rdata
    vecs[0]  = '{0, 1'b1, 11'h010,  32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 11'h010,  32'h0,        32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1, 1'b1, 11'h005,  32'hFFFFFFFF, 32'hFFFF0000, 1'b0, 32'h0};
    vecs[3]  = '{1, 1'b1, 11'h005,  32'h0000FFFF, 32'h1234ABCD, 1'b0, 32'h0};
    vecs[4]  = '{2, 1'b0, 11'h005,  32'h0,        32'h0,        1'b0, 32'hFFFFABCD};
    vecs[5]  = '{0, 1'b1, 11'h005,  32'h0,        32'h55555555, 1'b0, 32'h0};
    vecs[6]  = '{1, 1'b0, 11'h005,  32'h0,        32'h0,        1'b0, 32'hFFFFABCD};
    vecs[7]  = '{2, 1'b1, 11'h000,  32'hFFFFFFFF, 32'h11112222, 1'b0, 32'h0};
    vecs[8]  = '{0, 1'b1, 11'd1024, 32'hFFFFFFFF, 32'hAAAAAAAA, 1'b1, 32'h0};
    vecs[9]  = '{1, 1'b0, 11'h000,  32'h0,        32'h0,        1'b0, 32'h11112222};
    vecs[10] = '{2, 1'b0, 11'd2047, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[11] = '{0, 1'b1, 11'd1023, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 32'h0};
    vecs[12] = '{1, 1'b1, 11'd1023, 32'hFF00FF00, 32'hAAAAAAAA, 1'b0, 32'h0};
    vecs[13] = '{2, 1'b0, 11'd1023, 32'h0,        32'h0,        1'b0, 32'hAA0FAA0F};

    // reset state with requests asserted
    repeat (2) @(negedge clk);
    req = '1;
    #1;
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) do_txn(vecs[i]);

    // back-to-back write then read of the same word from one port
    @(negedge clk);
    set_port(0, 1'b1, 11'h007, 32'hFFFFFFFF, 32'hCAFEF00D);
    req = 3'b001;
    #1;
    chk("raw_gnt_wr", 64'(gnt), 64'(3'b001));
    exp_q.push_back(exp_entry(0, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 11'h007, 32'h0, 32'h0);
    @(negedge clk);
    chk("raw_gnt_rd", 64'(gnt), 64'(3'b001));
    exp_q.push_back(exp_entry(0, 1'b0, 32'hCAFEF00D));
    @(posedge clk);
    #1;
    req = '0;
    wait_drain("raw_drain");

    // reset to bring the pointer back to 0, then three-way contention
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cdata[0] = 32'hDEADBEEF; cdata[1] = 32'hFFFFABCD; cdata[2] = 32'h11112222;
    set_port(0, 1'b0, 11'h010, 32'h0, 32'h0);
    set_port(1, 1'b0, 11'h005, 32'h0, 32'h0);
    set_port(2, 1'b0, 11'h000, 32'h0, 32'h0);
    @(negedge clk);
    req = '1;
    for (int c = 0; c < 6; c++) begin
      logic [NP-1:0] oh;
      oh = 1;
      oh = oh << (c % 3);
      #1;
      chk("contention_gnt", 64'(gnt), 64'(oh));
      exp_q.push_back(exp_entry(c % 3, 1'b0, cdata[c % 3]));
      @(negedge clk);
    end
    req = '0;
    wait_drain("contention_drain");

    // one grant to port 0 moves the pointer to 1, then stall with ports 0 and 1 requesting
    v = '{0, 1'b0, 11'h010, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF};
    do_txn(v);
    @(negedge clk);
    stall = 1'b1;
    req = 3'b011;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_gnt", 64'(gnt), 64'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("post_stall_gnt", 64'(gnt), 64'(3'b010));
    exp_q.push_back(exp_entry(1, 1'b0, 32'hFFFFABCD));
    @(posedge clk);
    #1;
    req = '0;
    wait_drain("stall_drain");

    // reset one cycle after a grant: its response must never appear
    @(negedge clk);
    set_port(2, 1'b0, 11'h010, 32'h0, 32'h0);
    req = 3'b100;
    #1;
    chk("rst_mid_gnt", 64'(gnt), 64'(3'b100));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_gnt_low", 64'(gnt), 64'd0);
    chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mid_rdata", 64'(rdata), 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("rst_mid_quiet", 64'(rvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
